// File: rtl/online_pkg.sv
// rtl/online_pkg.sv - shared on-line arithmetic digit encoding, digit type and FSM state enum
package online_pkg;

  typedef logic [1:0] sd_digit_t;

  // Borrow-save digit: [1]=plus, [0]=minus; 2'b11 also decodes as zero
  localparam sd_digit_t SD_POS  = 2'b10;
  localparam sd_digit_t SD_NEG  = 2'b01;
  localparam sd_digit_t SD_ZERO = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } otf_state_t;

  function automatic logic sd_is_pos(sd_digit_t d);
    return d == SD_POS;
  endfunction

  function automatic logic sd_is_neg(sd_digit_t d);
    return d == SD_NEG;
  endfunction

endpackage

// File: rtl/otf_qqm_reg.sv
// rtl/otf_qqm_reg.sv - on-the-fly conversion Q/QM register pair (QM = Q - 1)
import online_pkg::*;

module otf_qqm_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         init,
  input  logic [1:0]   digit,
  output logic [W-1:0] q,
  output logic [W-1:0] qm,
  output logic [W-1:0] q_next
);

  logic [W-1:0] base_q;
  logic [W-1:0] base_qm;
  logic [W-1:0] qm_next;

  // Select frame-init or running values, then append the digit; no carry chain needed
  always_comb begin
    base_q  = init ? '0 : q;
    base_qm = init ? '1 : qm;
    q_next  = {base_q[W-2:0], 1'b0};
    qm_next = {base_qm[W-2:0], 1'b1};
    if (sd_is_pos(digit)) begin
      q_next  = {base_q[W-2:0], 1'b1};
      qm_next = {base_q[W-2:0], 1'b0};
    end else if (sd_is_neg(digit)) begin
      q_next  = {base_qm[W-2:0], 1'b1};
      qm_next = {base_qm[W-2:0], 1'b0};
    end
  end

  // Register pair advances only when a digit is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      qm <= '1;
    end else if (load) begin
      q  <= q_next;
      qm <= qm_next;
    end
  end

endmodule

// File: rtl/online_sd_to_binary.sv
// rtl/online_sd_to_binary.sv - MSD-first borrow-save digit stream to two's-complement word
import online_pkg::*;

module online_sd_to_binary #(
  parameter int NDIG = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          enable,
  input  logic [1:0]    digit_in,
  output logic          busy,
  output logic [NDIG:0] result,
  output logic          result_valid
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  otf_state_t    state;
  otf_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] idx;
  logic          frame_start;
  logic          consume;
  logic          last;
  logic          done;
  logic [NDIG:0] q;
  logic [NDIG:0] qm;
  logic [NDIG:0] q_next;

  // A start with enable always begins a new frame, aborting any frame in progress
  assign frame_start = start & enable;
  assign consume     = enable & (start | (state == CONV));
  assign idx         = frame_start ? '0 : cnt;
  assign last        = (idx == CW'(NDIG - 1));

  otf_qqm_reg #(
    .W(NDIG + 1)
  ) u_qqm (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (consume),
    .init   (frame_start),
    .digit  (digit_in),
    .q      (q),
    .qm     (qm),
    .q_next (q_next)
  );

  // Next-state, digit counter and frame-completion decode
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done       = 1'b0;
    if (consume) begin
      if (last) begin
        state_next = IDLE;
        cnt_next   = '0;
        done       = 1'b1;
      end else begin
        state_next = CONV;
        cnt_next   = idx + 1'b1;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Output registers: result captured on the edge that consumes the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= done;
      busy         <= (state_next == CONV);
      if (done) begin
        result <= q_next;
      end
    end
  end

endmodule
